// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the distributed-RAM write-port arbiter.
// Optional build macro: DRAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package dram_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int AW_MAX   = 7;
  localparam int NREQ_MAX = 8;
  localparam int PTR_W    = 3;

  // One-hot pick of the first set request at or after ptr, wrapping at n.
  function automatic logic [NREQ_MAX-1:0] rr_pick(
    input logic [NREQ_MAX-1:0] req,
    input logic [PTR_W-1:0]    ptr,
    input int                  n
  );
    logic [NREQ_MAX-1:0] g;
    logic                found;
    int                  idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n) begin
        if (!found && req[idx[PTR_W-1:0]]) begin
          g[idx[PTR_W-1:0]] = 1'b1;
          found             = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/dram_wport_arbiter_rr.sv
// Combinational write-port picker with its round-robin pointer register.
// DRAM_ARB_FIXED_PRIO_EN selects lowest-index-wins; starvation is then possible.
module dram_rr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o
);

  logic [NREQ_MAX-1:0] req_ext;
  logic [NREQ_MAX-1:0] pick;
  logic                unused_pick;

  assign req_ext     = NREQ_MAX'(req_i);
  assign unused_pick = ^pick;

`ifdef DRAM_ARB_FIXED_PRIO_EN

  logic unused_clk;

  assign unused_clk = clk_i ^ rst_ni;
  assign pick       = rr_pick(req_ext, '0, NREQ);
  assign gnt_o      = en_i ? pick[NREQ-1:0] : '0;

`else

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  assign pick  = rr_pick(req_ext, ptr_q, NREQ);
  assign gnt_o = en_i ? pick[NREQ-1:0] : '0;

  // Next search starts just past the winner; no grant keeps the pointer.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_o[i]) begin
        ptr_d = (i == NREQ-1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/dram_wport_arbiter.sv
// Shares one DRAM write port among NREQ requesters; clears the RAM after reset.
// Build macro DRAM_ARB_FIXED_PRIO_EN swaps round-robin for fixed priority.
module dram_wport_arbiter
  import dram_arb_pkg::*;
#(
  parameter int             NREQ      = 4,
  parameter int             AW        = 6,
  parameter int             DW        = 8,
  parameter logic [DW-1:0]  INIT_WORD = '0
) (
  input  logic              CLK1,
  input  logic              ARESETN,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  input  logic              clear_req,
  output logic              busy,
  output logic              ram_we,
  output logic [AW-1:0]     ram_waddr,
  output logic [DW-1:0]     ram_wdata
);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            arb_en;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // A clear request wins over every requester in the same cycle.
  assign arb_en = (state_q == RUN) && !clear_req;

  dram_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i  (CLK1),
    .rst_ni (ARESETN),
    .en_i   (arb_en),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr |= req_addr[i*AW +: AW] & {AW{gnt[i]}};
      sel_data |= req_data[i*DW +: DW] & {DW{gnt[i]}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = INIT_WORD;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        if (clear_req) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end else if (|gnt) begin
          we_d    = 1'b1;
          waddr_d = sel_addr;
          wdata_d = sel_data;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLK1 or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = (state_q == CLEAR);
  assign ram_we    = we_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;

endmodule
